serial_rx: RTL and testbench

// - UART receiver; downstream partner of the team's 8N1 transmitter on the same clk_in domain.
// - Sits at the far end of the serial line: synchronises data_in, finds the start bit, samples each bit at mid-period.
// - Delivers each received byte on data_out with a one-cycle valid_out strobe; flags bad stop bits on frame_err_out.

---
 rtl/serial_rx.sv | 158 +++++++++++++++
 tb/tb_serial_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_rx                                                      |
// | Brief   : 8N1 UART receiver, 2-flop input sync, mid-bit sampling.        |
// |           Optional macro RX_MAJORITY_EN: 3-sample majority vote.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module serial_rx #(
   parameter int DIVISOR    = 868,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  frame_err_out,
   output logic                  busy_out
);

   localparam int HALF        = DIVISOR / 2;
   localparam int COUNT_WIDTH = $clog2(DIVISOR + 1);
   localparam int IND_WIDTH   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_sync1, r_rx_s;
   logic [COUNT_WIDTH-1:0]  r_count, w_count_nxt;
   logic [IND_WIDTH-1:0]    r_ind, w_ind_nxt;
   logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
   logic [DATA_WIDTH-1:0]   r_data, w_data_nxt;
   logic                    r_valid, w_valid_nxt;
   logic                    r_ferr, w_ferr_nxt;
   logic                    r_armed, w_armed_nxt;
   logic                    w_sample;

`ifdef RX_MAJORITY_EN
   // Two previous rx_s values; majority with the current one rejects single-cycle glitches.
   logic [1:0] r_hist;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_hist <= 2'b11;
      end else begin
         r_hist <= {r_hist[0], r_rx_s};
      end
   end

   assign w_sample = (r_rx_s & r_hist[0]) | (r_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
   assign w_sample = r_rx_s;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_ind_nxt   = r_ind;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s && r_armed) begin
               w_state_nxt = S_START;
               w_count_nxt = '0;
            end
         end
         S_START: begin
            if (r_count == COUNT_WIDTH'(HALF)) begin
               w_count_nxt = '0;
               w_ind_nxt   = '0;
               w_state_nxt = w_sample ? S_IDLE : S_DATA;
            end else begin
               w_count_nxt = r_count + COUNT_WIDTH'(1);
            end
         end
         S_DATA: begin
            if (r_count == COUNT_WIDTH'(DIVISOR)) begin
               w_shift_nxt[r_ind] = w_sample;
               w_count_nxt        = '0;
               if (r_ind == IND_WIDTH'(DATA_WIDTH - 1)) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_ind_nxt = r_ind + IND_WIDTH'(1);
               end
            end else begin
               w_count_nxt = r_count + COUNT_WIDTH'(1);
            end
         end
         S_STOP: begin
            if (r_count == COUNT_WIDTH'(DIVISOR)) begin
               if (w_sample) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_ferr_nxt = 1'b1;
               end
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + COUNT_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end
      endcase

      // A framing error disarms until the line is seen high, so a held break cannot retrigger.
      w_armed_nxt = r_armed;
      if (w_ferr_nxt) begin
         w_armed_nxt = 1'b0;
      end else if (r_rx_s) begin
         w_armed_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_count <= '0;
         r_ind   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_sync1 <= data_in;
         r_rx_s  <= r_sync1;
         r_count <= w_count_nxt;
         r_ind   <= w_ind_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_armed <= w_armed_nxt;
      end
   end

   assign data_out      = r_data;
   assign valid_out     = r_valid;
   assign frame_err_out = r_ferr;
   assign busy_out      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_serial_rx                                                   |
// | Brief   : Directed self-checking bench for serial_rx (DIVISOR=15).       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_serial_rx;

   localparam int DIVISOR = 15;
   localparam int BIT     = DIVISOR + 1;
   localparam int HALF    = DIVISOR / 2;
   localparam int LAT     = HALF + 8 * BIT + BIT + 4;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       data_in = 1'b1;
   logic [7:0] data_out;
   logic       valid_out, frame_err_out, busy_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_valid = 0, n_ferr = 0, n_both = 0, n_busy = 0, valid_cyc = 0;
   logic [7:0] rx_q[$];
   int fall_cyc = 0;
   int v0, f0, b0, lat;

   serial_rx #(.DIVISOR(DIVISOR), .DATA_WIDTH(8)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .data_in       (data_in),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .frame_err_out (frame_err_out),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Strobes are recorded on the falling edge, well away from the update edge.
   always @(negedge clk_in) begin
      if (valid_out) begin
         n_valid++;
         rx_q.push_back(data_out);
         valid_cyc = cyc;
      end
      if (frame_err_out) n_ferr++;
      if (valid_out && frame_err_out) n_both++;
      if (busy_out) n_busy++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // glitch_bit >= 0 inverts that data bit for one cycle at its sample point.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
      data_in  = 1'b0;
      fall_cyc = cyc;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         data_in = b[i];
         if (i == glitch_bit) begin
            tick(HALF + 1);
            data_in = ~b[i];
            tick(1);
            data_in = b[i];
            tick(BIT - HALF - 2);
         end else begin
            tick(BIT);
         end
      end
      data_in = stop;
      tick(BIT);
   endtask

   initial begin
      // Reset
      rst_in  = 1'b1;
      data_in = 1'b1;
      tick(5);
      chk("rst_data", 32'(data_out), 32'h00);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_ferr", 32'(frame_err_out), 32'h0);
      chk("rst_busy", 32'(busy_out), 32'h0);
      rst_in = 1'b0;
      tick(5);

      // Single frame 0xA5
      send_frame(8'hA5, 1'b1, -1);
      tick(4);
      chk("a5_count", 32'(n_valid), 32'd1);
      chk("a5_data", 32'(data_out), 32'hA5);
      chk("a5_ferr", 32'(n_ferr), 32'd0);
      lat = valid_cyc - fall_cyc;
      chk("a5_latency", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);

      // Back-to-back 0x00, 0xFF
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      tick(4);
      chk("b2b_count", 32'(n_valid), 32'd3);
      chk("b2b_first", 32'(rx_q[1]), 32'h00);
      chk("b2b_second", 32'(rx_q[2]), 32'hFF);
      chk("b2b_ferr", 32'(n_ferr), 32'd0);

      // False start: 4-cycle low pulse
      b0 = n_busy;
      data_in = 1'b0;
      tick(4);
      data_in = 1'b1;
      tick(3 * BIT);
      chk("false_busy_seen", 32'(n_busy > b0), 32'd1);
      chk("false_idle", 32'(busy_out), 32'h0);
      chk("false_valid", 32'(n_valid), 32'd3);
      chk("false_ferr", 32'(n_ferr), 32'd0);

      // Framing error, held break, then 0x81
      send_frame(8'h3C, 1'b0, -1);
      chk("ferr_pulse", 32'(n_ferr), 32'd1);
      chk("ferr_keep_data", 32'(data_out), 32'hFF);
      chk("ferr_no_valid", 32'(n_valid), 32'd3);
      chk("ferr_never_both", 32'(n_both), 32'd0);
      b0 = n_busy;
      tick(40);
      chk("break_no_retrigger", 32'(n_busy - b0), 32'd0);
      data_in = 1'b1;
      tick(2 * BIT);
      send_frame(8'h81, 1'b1, -1);
      tick(4);
      chk("after_break_count", 32'(n_valid), 32'd4);
      chk("after_break_data", 32'(data_out), 32'h81);

      // Reset pulse during data bit 4 of 0xF0; bits 4..7 are high so nothing retriggers
      v0 = n_valid;
      f0 = n_ferr;
      data_in = 1'b0;
      tick(BIT);
      for (int i = 0; i < 4; i++) begin
         data_in = 1'b0;
         tick(BIT);
      end
      data_in = 1'b1;
      tick(HALF);
      rst_in = 1'b1;
      tick(1);
      rst_in = 1'b0;
      chk("abort_reset_data", 32'(data_out), 32'h00);
      tick(5 * BIT);
      chk("abort_no_valid", 32'(n_valid - v0), 32'd0);
      chk("abort_no_ferr", 32'(n_ferr - f0), 32'd0);
      send_frame(8'h5A, 1'b1, -1);
      tick(4);
      chk("post_abort_count", 32'(n_valid - v0), 32'd1);
      chk("post_abort_data", 32'(data_out), 32'h5A);

`ifdef RX_MAJORITY_EN
      // Glitch at the sample point of bit 0 (a zero bit) must be voted out
      tick(BIT);
      send_frame(8'h5A, 1'b1, 0);
      tick(4);
      chk("glitch_count", 32'(n_valid - v0), 32'd2);
      chk("glitch_data", 32'(data_out), 32'h5A);
      chk("glitch_ferr", 32'(n_ferr - f0), 32'd0);
`endif

      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
